// File: rtl/dct4_pkg.sv
// Shared constants, mode encoding and width helper for the 4-point HEVC transform.
package dct4_pkg;

  localparam logic [7:0] C64 = 8'd64;
  localparam logic [7:0] C83 = 8'd83;
  localparam logic [7:0] C36 = 8'd36;

  typedef enum logic {
    DCT4_FWD = 1'b0,
    DCT4_INV = 1'b1
  } dct4_mode_e;

  function automatic int acc_width(input int width_x);
    return width_x + 9;
  endfunction

endpackage

// File: rtl/dct4_round_sat.sv
// One output lane: rounding arithmetic right-shift, then wrap or clamp to WIDTH_Y.
// Define DCT4_PIPE_SAT_EN to clamp instead of wrapping.
module dct4_round_sat
  import dct4_pkg::*;
#(
  parameter int ACC_W   = 18,
  parameter int WIDTH_Y = 17,
  parameter int SHIFT_W = 4
) (
  input  logic [ACC_W-1:0]   i_acc,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [WIDTH_Y-1:0] o_y
);

  logic signed [ACC_W-1:0] w_bias;
  logic signed [ACC_W-1:0] w_round;

  always_comb begin
    w_bias = '0;
    if (i_shift != '0) begin
      w_bias = ACC_W'(1) << (i_shift - SHIFT_W'(1));
    end
  end

  assign w_round = ($signed(i_acc) + w_bias) >>> i_shift;

  generate
    if (WIDTH_Y >= ACC_W) begin : g_extend
      assign o_y = WIDTH_Y'(w_round);
    end else begin : g_narrow
`ifdef DCT4_PIPE_SAT_EN
      localparam logic signed [ACC_W-1:0] MAX_Y = {{(ACC_W-WIDTH_Y+1){1'b0}}, {(WIDTH_Y-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] MIN_Y = ~MAX_Y;

      always_comb begin
        if (w_round > MAX_Y) begin
          o_y = MAX_Y[WIDTH_Y-1:0];
        end else if (w_round < MIN_Y) begin
          o_y = MIN_Y[WIDTH_Y-1:0];
        end else begin
          o_y = w_round[WIDTH_Y-1:0];
        end
      end
`else
      assign o_y = WIDTH_Y'(w_round);
`endif
    end
  endgenerate

endmodule

// File: rtl/dct4_pipe.sv
// Two-stage pipelined 4-point HEVC forward/inverse core transform with valid/ready flow control.
// Define DCT4_PIPE_SAT_EN to saturate output lanes instead of wrapping.
module dct4_pipe
  import dct4_pkg::*;
#(
  parameter int WIDTH_X = 9,
  parameter int WIDTH_Y = 17,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [WIDTH_X-1:0] x0,
  input  logic [WIDTH_X-1:0] x1,
  input  logic [WIDTH_X-1:0] x2,
  input  logic [WIDTH_X-1:0] x3,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_Y-1:0] y0,
  output logic [WIDTH_Y-1:0] y1,
  output logic [WIDTH_Y-1:0] y2,
  output logic [WIDTH_Y-1:0] y3
);

  localparam int ACC_W = acc_width(WIDTH_X);

  // Shift-add constant multiply; with a constant coefficient only the set bits become adders.
  function automatic logic signed [ACC_W-1:0] cmul(input logic signed [ACC_W-1:0] v,
                                                   input logic [7:0] c);
    cmul = '0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) cmul = cmul + (v <<< i);
    end
  endfunction

  logic signed [ACC_W-1:0] w_x0, w_x1, w_x2, w_x3;
  logic signed [ACC_W-1:0] w_a0, w_a1, w_b0, w_b1;
  logic                    w_s2_load;

  logic                    r_s1_valid;
  logic                    r_s1_mode;
  logic [SHIFT_W-1:0]      r_s1_shift;
  logic signed [ACC_W-1:0] r_a0, r_a1, r_b0, r_b1;

  logic signed [ACC_W-1:0] w_p0, w_p1, w_q0, w_q1;
  logic signed [ACC_W-1:0] w_acc [4];
  logic [WIDTH_Y-1:0]      w_rnd [4];

  logic                    r_s2_valid;
  logic [WIDTH_Y-1:0]      r_y [4];

  assign w_x0 = ACC_W'($signed(x0));
  assign w_x1 = ACC_W'($signed(x1));
  assign w_x2 = ACC_W'($signed(x2));
  assign w_x3 = ACC_W'($signed(x3));

  always_comb begin
    if (mode == DCT4_INV) begin
      w_a0 = w_x0 + w_x2;
      w_a1 = w_x0 - w_x2;
      w_b0 = w_x1;
      w_b1 = w_x3;
    end else begin
      w_a0 = w_x0 + w_x3;
      w_a1 = w_x1 + w_x2;
      w_b0 = w_x0 - w_x3;
      w_b1 = w_x1 - w_x2;
    end
  end

  // A stage loads when empty or when its content is leaving this cycle.
  assign w_s2_load = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= DCT4_FWD;
      r_s1_shift <= '0;
      r_a0       <= '0;
      r_a1       <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode  <= mode;
        r_s1_shift <= shift;
        r_a0       <= w_a0;
        r_a1       <= w_a1;
        r_b0       <= w_b0;
        r_b1       <= w_b1;
      end
    end
  end

  // Even/odd products are shared; the two modes only differ in how they recombine.
  assign w_p0 = cmul(r_a0, C64);
  assign w_p1 = cmul(r_a1, C64);
  assign w_q0 = cmul(r_b0, C83) + cmul(r_b1, C36);
  assign w_q1 = cmul(r_b0, C36) - cmul(r_b1, C83);

  always_comb begin
    if (r_s1_mode == DCT4_INV) begin
      w_acc[0] = w_p0 + w_q0;
      w_acc[1] = w_p1 + w_q1;
      w_acc[2] = w_p1 - w_q1;
      w_acc[3] = w_p0 - w_q0;
    end else begin
      w_acc[0] = w_p0 + w_p1;
      w_acc[1] = w_q0;
      w_acc[2] = w_p0 - w_p1;
      w_acc[3] = w_q1;
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_lane
      dct4_round_sat #(
        .ACC_W  (ACC_W),
        .WIDTH_Y(WIDTH_Y),
        .SHIFT_W(SHIFT_W)
      ) u_round (
        .i_acc  (w_acc[g]),
        .i_shift(r_s1_shift),
        .o_y    (w_rnd[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_s2_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_y[i] <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < 4; i++) r_y[i] <= w_rnd[i];
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];

endmodule

// File: tb/tb_dct4_pipe.sv
// Directed self-checking bench for dct4_pipe: default-width instance plus a WIDTH_Y=12 instance
// for the wrap/saturate boundary (expectation follows DCT4_PIPE_SAT_EN).
module tb_dct4_pipe;

   localparam int WX  = 9;
   localparam int WY  = 17;
   localparam int SW  = 4;
   localparam int WYN = 12;

   logic clk = 1'b0;
   logic rst_b;
   logic in_valid, in_ready, mode, out_valid, out_ready;
   logic [SW-1:0] shift;
   logic [WX-1:0] x0, x1, x2, x3;
   logic [WY-1:0] y0, y1, y2, y3;

   logic n_in_valid, n_in_ready, n_out_valid;
   logic n_out_ready = 1'b1;
   logic [WYN-1:0] n_y0, n_y1, n_y2, n_y3;

   int total = 0;
   int bad = 0;

   // Free-running clock, 10 time-unit period
   always #5 clk = ~clk;

   dct4_pipe #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT_W(SW)) dut (
      .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .shift(shift), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3)
   );

   dct4_pipe #(.WIDTH_X(WX), .WIDTH_Y(WYN), .SHIFT_W(SW)) dutNarrow (
      .clk(clk), .rst_b(rst_b), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .mode(mode), .shift(shift), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .out_valid(n_out_valid), .out_ready(n_out_ready),
      .y0(n_y0), .y1(n_y1), .y2(n_y2), .y3(n_y3)
   );

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat's data fields (valid is handled by the caller)
   task automatic applyStimulus(input logic m, input int sh, input int a, input int b,
                                input int c, input int d);
      mode  = m;
      shift = SW'(sh);
      x0    = WX'(a);
      x1    = WX'(b);
      x2    = WX'(c);
      x3    = WX'(d);
   endtask

   // Reset values and the first cycle after release
   task automatic test_reset();
      rst_b = 1'b0;
      in_valid = 1'b0;
      n_in_valid = 1'b0;
      out_ready = 1'b1;
      applyStimulus(1'b0, 0, 0, 0, 0, 0);
      #2;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
      total++; if ({y0, y1, y2, y3} !== '0) begin bad++; $display("FAIL reset_y actual=%h required=0", {y0, y1, y2, y3}); end
      tick();
      tick();
      rst_b = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_out_valid actual=%b required=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready actual=%b required=1", in_ready); end
   endtask

   // Single isolated beats in both modes, checking latency and all four lanes
   task automatic test_transform();
      int vec [8][10] = '{
         '{0,  1, 1, 1,  1, 0, 256,   0,    0,   0},
         '{0,  1, 0, 0,  0, 0,  64,  83,   64,  36},
         '{0,  0, 0, 0,  1, 0,  64, -83,   64, -36},
         '{0,  0, 0, 0,  1, 1,  32, -41,   32, -18},
         '{0, -3, 5, 2, -7, 2, -48, 110, -272, -26},
         '{1, 64, 0, 0,  0, 7,  32,  32,   32,  32},
         '{1,  0, 1, 0,  0, 0,  83,  36,  -36, -83},
         '{1, 10,-2, 4,  3, 0, 838,  63,  705, 954}
      };
      int got [4];
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vec[i][0][0], vec[i][5], vec[i][1], vec[i][2], vec[i][3], vec[i][4]);
         in_valid = 1'b1;
         #1;
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vec%0d_in_ready actual=%b required=1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_early_valid actual=%b required=0", i, out_valid); end
         tick();
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_out_valid actual=%b required=1", i, out_valid); end
         got[0] = $signed(y0);
         got[1] = $signed(y1);
         got[2] = $signed(y2);
         got[3] = $signed(y3);
         for (int l = 0; l < 4; l++) begin
            total++;
            if (got[l] !== vec[i][6+l]) begin
               bad++;
               $display("FAIL vec%0d_y%0d actual=%0d required=%0d", i, l, got[l], vec[i][6+l]);
            end
         end
         tick();
      end
   endtask

   // Six back-to-back beats with out_ready low for cycles 3..5
   task automatic test_back_to_back();
      int inIdx = 0;
      int outIdx = 0;
      int occ = 0;
      logic prevStall = 1'b0;
      logic sawStall = 1'b0;
      logic expReady;
      logic [WY-1:0] prevY [4];
      int got [4];
      int exp [4];
      for (int c = 0; c < 30; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         if (inIdx < 6) begin
            applyStimulus(1'b0, 0, inIdx + 1, 0, 0, 0);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         expReady = (occ < 2) || out_ready;
         total++; if (in_ready !== expReady) begin bad++; $display("FAIL b2b_c%0d_in_ready actual=%b required=%b", c, in_ready, expReady); end
         if (prevStall) begin
            total++;
            if (out_valid !== 1'b1 || y0 !== prevY[0] || y1 !== prevY[1] || y2 !== prevY[2] || y3 !== prevY[3]) begin
               bad++;
               $display("FAIL b2b_c%0d_hold actual=%b/%h required=1/%h", c, out_valid, {y0, y1, y2, y3},
                        {prevY[0], prevY[1], prevY[2], prevY[3]});
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (outIdx >= 6) begin
               bad++;
               $display("FAIL b2b_extra_output actual=%0d required=6", outIdx + 1);
            end else begin
               got[0] = $signed(y0); got[1] = $signed(y1); got[2] = $signed(y2); got[3] = $signed(y3);
               exp[0] = 64 * (outIdx + 1); exp[1] = 83 * (outIdx + 1);
               exp[2] = 64 * (outIdx + 1); exp[3] = 36 * (outIdx + 1);
               if (got[0] !== exp[0] || got[1] !== exp[1] || got[2] !== exp[2] || got[3] !== exp[3]) begin
                  bad++;
                  $display("FAIL b2b_out%0d actual=%0d,%0d,%0d,%0d required=%0d,%0d,%0d,%0d", outIdx,
                           got[0], got[1], got[2], got[3], exp[0], exp[1], exp[2], exp[3]);
               end
            end
            outIdx++;
            occ--;
         end
         if (in_valid && in_ready) begin
            inIdx++;
            occ++;
         end
         if (!in_ready && !out_ready) sawStall = 1'b1;
         prevStall = out_valid && !out_ready;
         prevY[0] = y0; prevY[1] = y1; prevY[2] = y2; prevY[3] = y3;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      total++; if (outIdx != 6) begin bad++; $display("FAIL b2b_out_count actual=%0d required=6", outIdx); end
      total++; if (sawStall !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_low actual=%b required=1", sawStall); end
   endtask

   // Narrow output instance: wrap or clamp at the WIDTH_Y boundary
   task automatic test_width_boundary();
      int expY0;
`ifdef DCT4_PIPE_SAT_EN
      expY0 = 2047;
`else
      expY0 = -256;
`endif
      applyStimulus(1'b0, 0, 255, 255, 255, 255);
      n_in_valid = 1'b1;
      #1;
      total++; if (n_in_ready !== 1'b1) begin bad++; $display("FAIL narrow_in_ready actual=%b required=1", n_in_ready); end
      tick();
      n_in_valid = 1'b0;
      tick();
      total++; if (n_out_valid !== 1'b1) begin bad++; $display("FAIL narrow_out_valid actual=%b required=1", n_out_valid); end
      total++; if ($signed(n_y0) !== expY0) begin bad++; $display("FAIL narrow_y0 actual=%0d required=%0d", $signed(n_y0), expY0); end
      total++; if ($signed(n_y1) !== 0) begin bad++; $display("FAIL narrow_y1 actual=%0d required=0", $signed(n_y1)); end
      tick();
   endtask

   // Reset while two beats are held under backpressure, then recover
   task automatic test_reset_midflight();
      out_ready = 1'b0;
      applyStimulus(1'b0, 0, 2, 0, 0, 0);
      in_valid = 1'b1;
      tick();
      applyStimulus(1'b0, 0, 3, 0, 0, 0);
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid actual=%b required=1", out_valid); end
      total++; if ($signed(y0) !== 128) begin bad++; $display("FAIL midrst_pre_y0 actual=%0d required=128", $signed(y0)); end
      rst_b = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid actual=%b required=0", out_valid); end
      total++; if ({y0, y1, y2, y3} !== '0) begin bad++; $display("FAIL midrst_y actual=%h required=0", {y0, y1, y2, y3}); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready actual=%b required=1", in_ready); end
      tick();
      rst_b = 1'b1;
      out_ready = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_in_ready actual=%b required=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_release_valid actual=%b required=0", out_valid); end
      applyStimulus(1'b0, 0, 1, 0, 0, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_flushed_beat actual=%b required=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_next_valid actual=%b required=1", out_valid); end
      total++;
      if ($signed(y0) !== 64 || $signed(y1) !== 83 || $signed(y2) !== 64 || $signed(y3) !== 36) begin
         bad++;
         $display("FAIL midrst_next_y actual=%0d,%0d,%0d,%0d required=64,83,64,36",
                  $signed(y0), $signed(y1), $signed(y2), $signed(y3));
      end
      tick();
   endtask

   // Run every scenario in order and report
   initial begin
      test_reset();
      test_transform();
      test_back_to_back();
      test_width_boundary();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on simulation time
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
